// File: rtl/cce_mmio_cfg_loader_pkg.sv
// rtl/cce_mmio_cfg_loader_pkg.sv - Shared addresses, encodings and FSM states for the CCE config loader
package cce_mmio_cfg_loader_pkg;

  // bp_cfg register map
  localparam logic [63:0] CFG_ADDR_FREEZE     = 64'h20_0008;
  localparam logic [63:0] CFG_ADDR_CCE_MODE   = 64'h20_0018;
  localparam logic [63:0] CFG_ADDR_UCODE_BASE = 64'h20_8000;

  localparam logic [1:0] MEM_SIZE_8B     = 2'b11;
  localparam logic [3:0] MEM_OP_UC_STORE = 4'b0011;

  typedef logic [2:0] cfg_state_t;

  localparam cfg_state_t ST_RESET       = 3'd0;
  localparam cfg_state_t ST_SEND_FREEZE = 3'd1;
  localparam cfg_state_t ST_SEND_RAM    = 3'd2;
  localparam cfg_state_t ST_SEND_MODE   = 3'd3;
  localparam cfg_state_t ST_SEND_CLR    = 3'd4;
  localparam cfg_state_t ST_WAIT        = 3'd5;
  localparam cfg_state_t ST_DONE        = 3'd6;

endpackage

// File: rtl/cce_mmio_cfg_loader_credit_counter.sv
// rtl/cce_mmio_cfg_loader_credit_counter.sv - Outstanding-write credit counter, saturating at zero
module cfg_credit_counter #(
  parameter int max_p   = 4,
  parameter int width_p = $clog2(max_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               full_o
);

  logic [width_p-1:0] r_count;
  logic               w_down;

  // A response with nothing outstanding is spurious and dropped
  assign w_down = down_i && (r_count != '0);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_count <= '0;
    end else if (up_i && !w_down) begin
      r_count <= r_count + width_p'(1);
    end else if (!up_i && w_down) begin
      r_count <= r_count - width_p'(1);
    end
  end

  assign count_o = r_count;
  assign full_o  = (r_count == width_p'(max_p));

endmodule

// File: rtl/cce_mmio_cfg_loader.sv
// rtl/cce_mmio_cfg_loader.sv - Boot-time MMIO write sequencer: freeze, load CCE microcode, set mode
module cce_mmio_cfg_loader #(
  parameter int paddr_width_p         = 40,
  parameter int inst_width_p          = 48,
  parameter int inst_ram_els_p        = 256,
  parameter int inst_ram_addr_width_p = 8,
  parameter int lce_id_width_p        = 4,
  parameter int skip_ram_init_p       = 0,
  parameter int clear_freeze_p        = 0,
  parameter int cce_mode_p            = 1,
  parameter int io_credits_p          = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic [lce_id_width_p-1:0]        lce_id_i,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_yumi_i,
  output logic [paddr_width_p-1:0]         io_cmd_addr_o,
  output logic [63:0]                      io_cmd_data_o,
  output logic [lce_id_width_p-1:0]        io_cmd_src_o,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_ready_o,
  output logic [inst_ram_addr_width_p-1:0] rom_addr_o,
  input  logic [inst_width_p-1:0]          rom_data_i,
  output logic                             done_o
);

  import cce_mmio_cfg_loader_pkg::*;

  localparam int credit_width_lp = $clog2(io_credits_p + 1);

  cfg_state_t                       r_state;
  cfg_state_t                       w_state_next;
  logic [inst_ram_addr_width_p-1:0] r_index;
  logic                             r_done;
  logic                             w_send;
  logic                             w_full;
  logic                             w_yumi;
  logic                             w_last_entry;
  logic [credit_width_lp-1:0]       w_credit_count;
  logic [paddr_width_p-1:0]         w_addr;
  logic [63:0]                      w_data;

  cfg_credit_counter #(
    .max_p   (io_credits_p),
    .width_p (credit_width_lp)
  ) u_credit (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .up_i     (w_yumi),
    .down_i   (io_resp_v_i),
    .count_o  (w_credit_count),
    .full_o   (w_full)
  );

  assign w_send = (r_state == ST_SEND_FREEZE) || (r_state == ST_SEND_RAM)
               || (r_state == ST_SEND_MODE)   || (r_state == ST_SEND_CLR);

  assign io_cmd_v_o   = w_send && !w_full;
  // Yumi is only honoured while a command is actually offered
  assign w_yumi       = io_cmd_yumi_i && io_cmd_v_o;
  assign w_last_entry = (r_index == inst_ram_addr_width_p'(inst_ram_els_p - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RESET:       w_state_next = ST_SEND_FREEZE;
      ST_SEND_FREEZE: if (w_yumi) w_state_next = (skip_ram_init_p != 0) ? ST_SEND_MODE : ST_SEND_RAM;
      ST_SEND_RAM:    if (w_yumi && w_last_entry) w_state_next = ST_SEND_MODE;
      ST_SEND_MODE:   if (w_yumi) w_state_next = (clear_freeze_p != 0) ? ST_SEND_CLR : ST_WAIT;
      ST_SEND_CLR:    if (w_yumi) w_state_next = ST_WAIT;
      ST_WAIT:        if (w_credit_count == '0) w_state_next = ST_DONE;
      ST_DONE:        w_state_next = ST_DONE;
      default:        w_state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_RESET;
      r_index <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_SEND_RAM) && w_yumi) begin
        r_index <= w_last_entry ? '0 : r_index + inst_ram_addr_width_p'(1);
      end
      if ((r_state == ST_WAIT) && (w_credit_count == '0)) begin
        r_done <= 1'b1;
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    case (r_state)
      ST_SEND_FREEZE: begin
        w_addr = paddr_width_p'(CFG_ADDR_FREEZE);
        w_data = 64'd1;
      end
      ST_SEND_RAM: begin
        w_addr = paddr_width_p'(CFG_ADDR_UCODE_BASE) + paddr_width_p'({r_index, 3'b000});
        w_data = 64'(rom_data_i);
      end
      ST_SEND_MODE: begin
        w_addr = paddr_width_p'(CFG_ADDR_CCE_MODE);
        w_data = 64'(cce_mode_p);
      end
      ST_SEND_CLR: begin
        w_addr = paddr_width_p'(CFG_ADDR_FREEZE);
        w_data = 64'd0;
      end
      default: ;
    endcase
  end

  assign io_cmd_addr_o   = w_addr;
  assign io_cmd_data_o   = w_data;
  assign io_cmd_src_o    = lce_id_i;
  assign io_resp_ready_o = reset_ni;
  assign rom_addr_o      = r_index;
  assign done_o          = r_done;

endmodule

// File: tb/tb_cce_mmio_cfg_loader.sv
// tb/tb_cce_mmio_cfg_loader.sv - Randomized self-checking bench for the CCE config loader
module tb_cce_mmio_cfg_loader;

  localparam logic [39:0] FREEZE_A = 40'h20_0008;
  localparam logic [39:0] MODE_A   = 40'h20_0018;
  localparam logic [39:0] UCODE_A  = 40'h20_8000;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] rom_mem [256];

  logic        a_rst_n, a_yumi, a_resp, a_v, a_ready, a_done;
  logic [3:0]  a_lce, a_src;
  logic [39:0] a_addr;
  logic [63:0] a_data;
  logic [7:0]  a_rom_addr;
  logic [47:0] a_rom_data;

  logic        b_rst_n, b_yumi, b_resp, b_v, b_ready, b_done;
  logic [3:0]  b_lce, b_src;
  logic [39:0] b_addr;
  logic [63:0] b_data;
  logic [7:0]  b_rom_addr;
  logic [47:0] b_rom_data;

  assign a_rom_data = rom_mem[a_rom_addr];
  assign b_rom_data = rom_mem[b_rom_addr];

  cce_mmio_cfg_loader #(.clear_freeze_p(1)) dut_a (
    .clk_i(clk), .reset_ni(a_rst_n), .lce_id_i(a_lce),
    .io_cmd_v_o(a_v), .io_cmd_yumi_i(a_yumi), .io_cmd_addr_o(a_addr),
    .io_cmd_data_o(a_data), .io_cmd_src_o(a_src), .io_resp_v_i(a_resp),
    .io_resp_ready_o(a_ready), .rom_addr_o(a_rom_addr), .rom_data_i(a_rom_data),
    .done_o(a_done)
  );

  cce_mmio_cfg_loader #(.skip_ram_init_p(1), .clear_freeze_p(0)) dut_b (
    .clk_i(clk), .reset_ni(b_rst_n), .lce_id_i(b_lce),
    .io_cmd_v_o(b_v), .io_cmd_yumi_i(b_yumi), .io_cmd_addr_o(b_addr),
    .io_cmd_data_o(b_data), .io_cmd_src_o(b_src), .io_resp_v_i(b_resp),
    .io_resp_ready_o(b_ready), .rom_addr_o(b_rom_addr), .rom_data_i(b_rom_data),
    .done_o(b_done)
  );

  // Resets A, then plays the whole write series with a random-acceptance,
  // random-latency responder, checking every command against the expected list.
  task automatic run_a(input int yumi_pct, input int max_lat, input int abort_at, input bit check_timing);
    logic [39:0] exp_addr [$];
    logic [63:0] exp_data [$];
    int due [$];
    int k, outstanding, last_resp, total, d, first_done;
    bit exp_v, exp_done;
    exp_addr.push_back(FREEZE_A); exp_data.push_back(64'd1);
    for (int i = 0; i < 256; i++) begin
      exp_addr.push_back(UCODE_A + 40'(8 * i));
      exp_data.push_back({16'h0, rom_mem[i]});
    end
    exp_addr.push_back(MODE_A);   exp_data.push_back(64'd1);
    exp_addr.push_back(FREEZE_A); exp_data.push_back(64'd0);
    total = exp_addr.size();

    @(negedge clk); a_rst_n = 1'b0; a_yumi = 1'b0; a_resp = 1'b0;
    @(negedge clk); a_rst_n = 1'b1;
    #1;
    checks++; if (a_v !== 1'b0) begin errors++; $display("FAIL release_valid got=%b exp=0", a_v); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", a_ready); end

    k = 0; outstanding = 0; last_resp = -100; first_done = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      exp_v = (k < total) && (outstanding < 4);
      exp_done = (k == total) && (outstanding == 0) && (cyc >= last_resp + 2);
      checks++; if (a_v !== exp_v) begin errors++; $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, a_v, exp_v); end
      checks++; if (a_done !== exp_done) begin errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, a_done, exp_done); end
      if (k >= 1 && k <= 256) begin
        checks++; if (a_rom_addr !== 8'(k - 1)) begin errors++; $display("FAIL rom_addr got=%0d exp=%0d", a_rom_addr, k - 1); end
      end
      if (a_done === 1'b1 && first_done < 0) first_done = cyc;
      if (abort_at >= 0 && k == abort_at) begin
        a_yumi = 1'b0; a_resp = 1'b0; a_rst_n = 1'b0;
        #1;
        checks++; if (a_v !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", a_v); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", a_done); end
        checks++; if (a_rom_addr !== 8'd0) begin errors++; $display("FAIL abort_rom_addr got=%0d exp=0", a_rom_addr); end
        checks++; if (a_addr !== 40'd0 || a_data !== 64'd0) begin errors++; $display("FAIL abort_cmd got=%h/%h exp=0/0", a_addr, a_data); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", a_ready); end
        return;
      end
      if (exp_done && cyc >= last_resp + 5) break;

      a_yumi = a_v && ($urandom_range(99) < yumi_pct);
      if (a_yumi === 1'b1) begin
        if (k < total) begin
          checks++;
          if (a_addr !== exp_addr[k] || a_data !== exp_data[k]) begin
            errors++; $display("FAIL cmd%0d got=%h/%h exp=%h/%h", k, a_addr, a_data, exp_addr[k], exp_data[k]);
          end
        end
        if (check_timing) begin
          checks++; if (cyc != k) begin errors++; $display("FAIL issue_cycle cmd%0d got=%0d exp=%0d", k, cyc, k); end
        end
        k++; outstanding++;
        d = cyc + int'($urandom_range(max_lat, 1));
        if (due.size() > 0 && d < due[$]) d = due[$];
        due.push_back(d);
      end
      a_resp = 1'b0;
      if (due.size() > 0 && due[0] <= cyc) begin
        a_resp = 1'b1; void'(due.pop_front()); outstanding--; last_resp = cyc;
      end
    end
    a_yumi = 1'b0; a_resp = 1'b0;
    checks++; if (k != total) begin errors++; $display("FAIL cmd_count got=%0d exp=%0d", k, total); end
    checks++; if (first_done < 0) begin errors++; $display("FAIL done_timeout got=none exp=done"); end
    if (check_timing) begin
      checks++; if (first_done != total + 2) begin errors++; $display("FAIL done_cycle got=%0d exp=%0d", first_done, total + 2); end
    end
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_yumi = 1'b0; a_resp = 1'b0; b_yumi = 1'b0; b_resp = 1'b0;
    @(negedge clk);
    checks++; if (a_v !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", a_v); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end
    checks++; if (a_rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr got=%0d exp=0", a_rom_addr); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", a_ready); end
    checks++; if (a_src !== a_lce) begin errors++; $display("FAIL src got=%h exp=%h", a_src, a_lce); end
    checks++; if (b_v !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL reset_b got=%b%b exp=00", b_v, b_done); end
  endtask

  task automatic test_full_sequence();
    for (int i = 0; i < 256; i++) rom_mem[i] = 48'(i);
    run_a(100, 1, -1, 1'b1);
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 256; i++) rom_mem[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    run_a(70, 6, -1, 1'b0);
  endtask

  task automatic test_credit_stall();
    int yumis;
    @(negedge clk); a_rst_n = 1'b0; a_yumi = 1'b0; a_resp = 1'b0;
    @(negedge clk); a_rst_n = 1'b1;
    yumis = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); a_yumi = a_v; a_resp = 1'b0;
      if (a_yumi === 1'b1) yumis++;
    end
    @(negedge clk); a_yumi = 1'b0;
    checks++; if (yumis != 4) begin errors++; $display("FAIL stall_yumis got=%0d exp=4", yumis); end
    checks++; if (a_v !== 1'b0) begin errors++; $display("FAIL stall_valid got=%b exp=0", a_v); end
    a_resp = 1'b1;
    @(negedge clk); a_resp = 1'b0;
    yumis = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); a_yumi = a_v;
      if (a_yumi === 1'b1) yumis++;
    end
    @(negedge clk); a_yumi = 1'b0;
    checks++; if (yumis != 1) begin errors++; $display("FAIL release_one got=%0d exp=1", yumis); end
    checks++; if (a_v !== 1'b0) begin errors++; $display("FAIL restall_valid got=%b exp=0", a_v); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk); a_rst_n = 1'b0; a_yumi = 1'b0; a_resp = 1'b0;
    @(negedge clk); a_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (a_v !== 1'b1) begin errors++; $display("FAIL fill_valid%0d got=%b exp=1", c, a_v); end
      a_yumi = 1'b1;
    end
    @(negedge clk);
    checks++; if (a_v !== 1'b1 || a_addr !== UCODE_A + 40'd16) begin
      errors++; $display("FAIL both_pre got=%b/%h exp=1/%h", a_v, a_addr, UCODE_A + 40'd16);
    end
    a_yumi = 1'b1; a_resp = 1'b1;
    @(negedge clk); a_yumi = 1'b0; a_resp = 1'b0;
    checks++; if (a_v !== 1'b1 || a_addr !== UCODE_A + 40'd24) begin
      errors++; $display("FAIL both_post got=%b/%h exp=1/%h", a_v, a_addr, UCODE_A + 40'd24);
    end
    checks++; if (dut_a.w_credit_count !== 3'd3) begin errors++; $display("FAIL both_count got=%0d exp=3", dut_a.w_credit_count); end
    a_yumi = 1'b1;
    @(negedge clk); a_yumi = 1'b0;
    checks++; if (a_v !== 1'b0) begin errors++; $display("FAIL fourth_full got=%b exp=0", a_v); end
  endtask

  task automatic test_reset_mid_sequence();
    for (int i = 0; i < 256; i++) rom_mem[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    run_a(80, 3, 101, 1'b0);
    run_a(100, 1, -1, 1'b0);
  endtask

  task automatic test_done_spurious();
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL pre_spur_done got=%b exp=1", a_done); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); a_resp = 1'b1;
    end
    @(negedge clk); a_resp = 1'b0;
    @(negedge clk);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL spur_done got=%b exp=1", a_done); end
    checks++; if (dut_a.w_credit_count !== 3'd0) begin errors++; $display("FAIL spur_count got=%0d exp=0", dut_a.w_credit_count); end
  endtask

  task automatic test_skip_ram();
    logic [39:0] got_a [$];
    logic [63:0] got_d [$];
    bit prev_yumi, seen_done;
    @(negedge clk); b_rst_n = 1'b0; b_yumi = 1'b0; b_resp = 1'b0;
    @(negedge clk); b_rst_n = 1'b1;
    prev_yumi = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      @(negedge clk);
      checks++; if (b_rom_addr !== 8'd0) begin errors++; $display("FAIL skip_rom_addr got=%0d exp=0", b_rom_addr); end
      seen_done = (b_done === 1'b1);
      b_resp = prev_yumi;
      b_yumi = b_v;
      if (b_yumi === 1'b1) begin got_a.push_back(b_addr); got_d.push_back(b_data); end
      prev_yumi = (b_yumi === 1'b1);
    end
    b_yumi = 1'b0; b_resp = 1'b0;
    checks++; if (!seen_done) begin errors++; $display("FAIL skip_done got=0 exp=1"); end
    checks++;
    if (got_a.size() != 2) begin
      errors++; $display("FAIL skip_count got=%0d exp=2", got_a.size());
    end else if (got_a[0] !== FREEZE_A || got_d[0] !== 64'd1 || got_a[1] !== MODE_A || got_d[1] !== 64'd1) begin
      errors++; $display("FAIL skip_cmds got=%h/%h,%h/%h exp=%h/1,%h/1", got_a[0], got_d[0], got_a[1], got_d[1], FREEZE_A, MODE_A);
    end
  endtask

  initial begin
    a_lce = 4'($urandom); b_lce = 4'($urandom);
    test_reset();
    test_full_sequence();
    test_random_traffic();
    test_credit_stall();
    test_same_cycle();
    test_reset_mid_sequence();
    test_done_spurious();
    test_skip_ram();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
